// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter
// Shares the single write port of the TX async FIFO among three byte
// producers: register-file read responses (requester 0), ALU results
// (requester 1, sent as two bytes LSB first) and UART status reports
// (requester 2). Each requester has a one-deep holding buffer. Grants are
// round-robin, and each grant is serialised into FIFO byte writes under
// FIFO-full backpressure. A request that arrives while its buffer is still
// occupied is dropped, and that requester's sticky overflow flag is set.
//
// Ports
//   CLK        REF_CLK domain clock
//   RST        asynchronous, active-high reset
//   rd_data    register-file read data, qualified by rd_vld
//   alu_out    ALU result (2*DATA_WIDTH), qualified by alu_vld
//   sts_data   status byte, qualified by sts_vld
//   fifo_full  FIFO full flag; no write is issued while it is high
//   ovf_clr    clears ovf_flags (a simultaneous new drop wins)
//   w_inc      FIFO write strobe (combinational)
//   w_data     FIFO write data, zero when no write is active
//   busy       any request pending or a grant in progress
//   ovf_flags  sticky drop flags, bit i = requester i
module tx_fifo_arbiter #(
  parameter int DATA_WIDTH    = 8,
  // Must equal 2*DATA_WIDTH.
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_vld,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     alu_vld,
  input  logic [DATA_WIDTH-1:0]    sts_data,
  input  logic                     sts_vld,
  input  logic                     fifo_full,
  input  logic                     ovf_clr,
  output logic                     w_inc,
  output logic [DATA_WIDTH-1:0]    w_data,
  output logic                     busy,
  output logic [2:0]               ovf_flags
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t                   state_q;
  logic [1:0]               grant_q;
  logic [1:0]               rrPtr_q;
  logic [2:0]               pending_q;
  logic [2:0]               pending_d;
  logic [2:0]               ovf_q;
  logic [2:0]               ovf_d;
  logic [DATA_WIDTH-1:0]    rdHold_q;
  logic [ALU_OUT_WIDTH-1:0] aluHold_q;
  logic [DATA_WIDTH-1:0]    stsHold_q;

  logic                     writeActive;
  logic [DATA_WIDTH-1:0]    sendByte;
  logic [2:0]               pendingClr;
  logic [2:0]               reqVld;
  logic [2:0]               capture;
  logic [2:0]               drop;
  logic [1:0]               scanFirst;
  logic [1:0]               scanSecond;
  logic [1:0]               arbGrant;

  // A write happens in any sending state as long as the FIFO can take it.
  // The byte being presented is selected by the latched grant; the ALU MSB
  // is only ever sent from SEND_HI.
  always_comb begin
    writeActive = (state_q != IDLE) && !fifo_full;
    sendByte    = '0;
    unique case (grant_q)
      2'd0:    sendByte = rdHold_q;
      2'd1:    sendByte = aluHold_q[DATA_WIDTH-1:0];
      2'd2:    sendByte = stsHold_q;
      default: sendByte = '0;
    endcase
    w_inc  = writeActive;
    w_data = '0;
    if (writeActive) begin
      w_data = (state_q == SEND_HI) ? aluHold_q[ALU_OUT_WIDTH-1:DATA_WIDTH] : sendByte;
    end
    busy      = (|pending_q) || (state_q != IDLE);
    ovf_flags = ovf_q;
  end

  // The pending bit of the granted requester is released on its final byte
  // write. A release frees the buffer in the same cycle, so a new valid for
  // that requester on this edge is captured rather than dropped.
  always_comb begin
    pendingClr = '0;
    if (writeActive) begin
      if (state_q == SEND_HI) begin
        pendingClr[1] = 1'b1;
      end else if (grant_q != 2'd1) begin
        pendingClr[grant_q] = 1'b1;
      end
    end
    reqVld    = {sts_vld, alu_vld, rd_vld};
    capture   = reqVld & (~pending_q | pendingClr);
    drop      = reqVld & pending_q & ~pendingClr;
    pending_d = (pending_q & ~pendingClr) | capture;
    // Clear first so that a drop in the same cycle leaves its flag set.
    ovf_d     = (ovf_q & ~{3{ovf_clr}}) | drop;
  end

  // Round-robin scan order starts just after the last served requester:
  // rr+1, rr+2, then rr itself.
  always_comb begin
    scanFirst  = 2'd0;
    scanSecond = 2'd1;
    unique case (rrPtr_q)
      2'd0: begin
        scanFirst  = 2'd1;
        scanSecond = 2'd2;
      end
      2'd1: begin
        scanFirst  = 2'd2;
        scanSecond = 2'd0;
      end
      default: begin
        scanFirst  = 2'd0;
        scanSecond = 2'd1;
      end
    endcase
    if (pending_q[scanFirst]) begin
      arbGrant = scanFirst;
    end else if (pending_q[scanSecond]) begin
      arbGrant = scanSecond;
    end else begin
      arbGrant = rrPtr_q;
    end
  end

  // Holding buffers, pending bits and sticky overflow flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdHold_q  <= '0;
      aluHold_q <= '0;
      stsHold_q <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      if (capture[0]) rdHold_q  <= rd_data;
      if (capture[1]) aluHold_q <= alu_out;
      if (capture[2]) stsHold_q <= sts_data;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Grant state machine. rrPtr resets to 2 so requester 0 is scanned first.
  // The ALU grant runs SEND -> SEND_HI without returning to IDLE, so no other
  // requester can slip in between its two bytes. Every grant ends with one
  // IDLE cycle in which the next winner is chosen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rrPtr_q <= 2'd2;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pending_q) begin
            grant_q <= arbGrant;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (writeActive) begin
            if (grant_q == 2'd1) begin
              state_q <= SEND_HI;
            end else begin
              rrPtr_q <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        SEND_HI: begin
          if (writeActive) begin
            rrPtr_q <= 2'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter
// Drives tx_fifo_arbiter with directed scenarios followed by a random phase.
// A transaction-level reference model predicts, every cycle, the write strobe,
// the write byte, busy and the overflow flags. The model keeps one occupied
// slot per requester and a queue of bytes for the grant currently being sent.
// Byte logs of the DUT writes are also compared against literal sequences.
module tb_tx_fifo_arbiter;

  logic        CLK;
  logic        RST;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [15:0] alu_out;
  logic        alu_vld;
  logic [7:0]  sts_data;
  logic        sts_vld;
  logic        fifo_full;
  logic        ovf_clr;
  logic        w_inc;
  logic [7:0]  w_data;
  logic        busy;
  logic [2:0]  ovf_flags;

  int total;
  int bad;

  // Reference model state.
  logic [2:0]  mOcc;
  logic [15:0] mVal [3];
  logic [7:0]  mBurst [$];
  int          mOwner;
  int          mLast;
  logic [2:0]  mOvf;

  logic [7:0]  wrLog [$];

  tx_fifo_arbiter #(
    .DATA_WIDTH   (8),
    .ALU_OUT_WIDTH(16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .alu_out  (alu_out),
    .alu_vld  (alu_vld),
    .sts_data (sts_data),
    .sts_vld  (sts_vld),
    .fifo_full(fifo_full),
    .ovf_clr  (ovf_clr),
    .w_inc    (w_inc),
    .w_data   (w_data),
    .busy     (busy),
    .ovf_flags(ovf_flags)
  );

  // 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One comparison: counts it, and on mismatch reports and counts the failure.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOcc   = '0;
    mBurst.delete();
    mOwner = 0;
    mLast  = 2;
    mOvf   = '0;
    for (int i = 0; i < 3; i++) mVal[i] = '0;
  endtask

  // Advance the model across one clock edge using the inputs of this cycle.
  task automatic modelEdge();
    bit          inc;
    bit          wasIdle;
    bit          found;
    int          c;
    logic [2:0]  vldVec;
    logic [15:0] din [3];
    inc     = (mBurst.size() != 0) && !fifo_full;
    wasIdle = (mBurst.size() == 0);
    vldVec  = {sts_vld, alu_vld, rd_vld};
    din[0]  = {8'h00, rd_data};
    din[1]  = alu_out;
    din[2]  = {8'h00, sts_data};
    if (inc) begin
      void'(mBurst.pop_front());
      if (mBurst.size() == 0) begin
        mOcc[mOwner] = 1'b0;
        mLast        = mOwner;
      end
    end
    if (wasIdle && (mOcc != 0)) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (mLast + k) % 3;
        if (!found && mOcc[c]) begin
          found  = 1;
          mOwner = c;
        end
      end
      mBurst.push_back(mVal[mOwner][7:0]);
      if (mOwner == 1) mBurst.push_back(mVal[1][15:8]);
    end
    if (ovf_clr) mOvf = '0;
    for (int x = 0; x < 3; x++) begin
      if (vldVec[x]) begin
        if (!mOcc[x]) begin
          mOcc[x] = 1'b1;
          mVal[x] = din[x];
        end else begin
          mOvf[x] = 1'b1;
        end
      end
    end
  endtask

  // Check outputs mid-cycle against the model, then cross one edge.
  task automatic stepCycle();
    logic       expInc;
    logic [7:0] expData;
    logic       expBusy;
    @(negedge CLK);
    expInc  = (mBurst.size() != 0) && !fifo_full;
    expData = expInc ? mBurst[0] : 8'h00;
    expBusy = (mOcc != 0) || (mBurst.size() != 0);
    checkOutput("w_inc", {15'd0, w_inc}, {15'd0, expInc});
    checkOutput("w_data", {8'd0, w_data}, {8'd0, expData});
    checkOutput("busy", {15'd0, busy}, {15'd0, expBusy});
    checkOutput("ovf_flags", {13'd0, ovf_flags}, {13'd0, mOvf});
    if (w_inc === 1'b1) wrLog.push_back(w_data);
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  // Drive one cycle worth of inputs, then step.
  task automatic applyStimulus(input logic rdV, input logic [7:0] rdD,
                               input logic aluV, input logic [15:0] aluD,
                               input logic stsV, input logic [7:0] stsD,
                               input logic full, input logic clr);
    rd_vld    = rdV;
    rd_data   = rdD;
    alu_vld   = aluV;
    alu_out   = aluD;
    sts_vld   = stsV;
    sts_data  = stsD;
    fifo_full = full;
    ovf_clr   = clr;
    stepCycle();
  endtask

  task automatic idleCycles(input int n, input logic full);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 16'h0000, 0, 8'h00, full, 0);
  endtask

  // Compare the logged DUT writes with a literal byte sequence, then clear it.
  task automatic checkLog(input string tag, input int n,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0;
    exp[1] = e1;
    exp[2] = e2;
    exp[3] = e3;
    checkOutput({tag, "_count"}, 16'(wrLog.size()), 16'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wrLog.size()) checkOutput($sformatf("%s_byte%0d", tag, i), {8'd0, wrLog[i]}, {8'd0, exp[i]});
    end
    wrLog.delete();
  endtask

  // Assert reset away from the clock edge and check that outputs drop at once.
  task automatic doReset();
    RST       = 1'b1;
    rd_vld    = 0;
    alu_vld   = 0;
    sts_vld   = 0;
    fifo_full = 0;
    ovf_clr   = 0;
    #1;
    checkOutput("rst_w_inc", {15'd0, w_inc}, 16'd0);
    checkOutput("rst_w_data", {8'd0, w_data}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_ovf", {13'd0, ovf_flags}, 16'd0);
    modelReset();
    wrLog.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    RST       = 1'b1;
    rd_data   = '0;
    rd_vld    = 0;
    alu_out   = '0;
    alu_vld   = 0;
    sts_data  = '0;
    sts_vld   = 0;
    fifo_full = 0;
    ovf_clr   = 0;
    modelReset();
    #3;
    doReset();

    $display("[TB] single register read response");
    applyStimulus(1, 8'hA5, 0, 16'h0000, 0, 8'h00, 0, 0);
    idleCycles(4, 0);
    checkLog("rd_single", 1, 8'hA5, 8'h00, 8'h00, 8'h00);
    checkOutput("rd_busy_end", {15'd0, busy}, 16'd0);

    $display("[TB] ALU result LSB then MSB");
    applyStimulus(0, 8'h00, 1, 16'h1234, 0, 8'h00, 0, 0);
    idleCycles(5, 0);
    checkLog("alu_single", 2, 8'h34, 8'h12, 8'h00, 8'h00);

    $display("[TB] round-robin continues after ALU grant");
    applyStimulus(1, 8'h21, 0, 16'h0000, 1, 8'h43, 0, 0);
    idleCycles(6, 0);
    checkLog("rr_after_alu", 2, 8'h43, 8'h21, 8'h00, 8'h00);

    $display("[TB] three simultaneous requests from reset");
    doReset();
    applyStimulus(1, 8'h11, 1, 16'hBEEF, 1, 8'h7E, 0, 0);
    idleCycles(10, 0);
    checkLog("all_three", 4, 8'h11, 8'hEF, 8'hBE, 8'h7E);

    $display("[TB] backpressure between ALU LSB and MSB");
    applyStimulus(0, 8'h00, 1, 16'h1234, 0, 8'h00, 0, 0);
    idleCycles(2, 0);
    applyStimulus(1, 8'h55, 0, 16'h0000, 0, 8'h00, 1, 0);
    idleCycles(3, 1);
    checkOutput("hi_hold_inc", {15'd0, w_inc}, 16'd0);
    checkOutput("hi_hold_busy", {15'd0, busy}, 16'd1);
    idleCycles(1, 1);
    idleCycles(8, 0);
    checkLog("hi_backpressure", 3, 8'h34, 8'h12, 8'h55, 8'h00);

    $display("[TB] overflow on occupied buffer");
    applyStimulus(1, 8'h01, 0, 16'h0000, 0, 8'h00, 1, 0);
    idleCycles(1, 1);
    applyStimulus(1, 8'h02, 0, 16'h0000, 0, 8'h00, 1, 0);
    idleCycles(1, 1);
    checkOutput("ovf_set", {13'd0, ovf_flags}, 16'h0001);
    idleCycles(5, 0);
    checkLog("ovf_written", 1, 8'h01, 8'h00, 8'h00, 8'h00);
    applyStimulus(0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1);
    checkOutput("ovf_cleared", {13'd0, ovf_flags}, 16'h0000);

    $display("[TB] reset during ALU MSB phase");
    applyStimulus(0, 8'h00, 1, 16'h1234, 0, 8'h00, 0, 0);
    idleCycles(2, 0);
    checkLog("pre_reset", 1, 8'h34, 8'h00, 8'h00, 8'h00);
    doReset();
    applyStimulus(0, 8'h00, 0, 16'h0000, 1, 8'h7E, 0, 0);
    idleCycles(4, 0);
    checkLog("post_reset", 1, 8'h7E, 8'h00, 8'h00, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom),
                    $urandom_range(0, 4) == 0, 16'($urandom),
                    $urandom_range(0, 3) == 0, 8'($urandom),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
    end
    idleCycles(12, 0);
    checkOutput("rand_busy_end", {15'd0, busy}, 16'd0);
    wrLog.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
